// File: rtl/wb_master_bridge.sv
// Wishbone classic master bridge: valid/ready request/response to single
// B3 bus cycles, one outstanding, with a cycle-count timeout reported as error.
module wb_master_bridge #(
  parameter int addr_width     = 8,
  parameter int data_width     = 32,
  parameter int strobe_width   = data_width / 8,
  parameter int timeout_cycles = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [addr_width-1:0]   req_addr,
  input  logic [data_width-1:0]   req_data,
  input  logic                    req_we,
  input  logic [strobe_width-1:0] req_sel,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [data_width-1:0]   resp_data,
  output logic                    resp_err,
  output logic [addr_width-1:0]   wb_adr,
  output logic [data_width-1:0]   wb_datwr,
  input  logic [data_width-1:0]   wb_datrd,
  output logic                    wb_we,
  output logic [strobe_width-1:0] wb_sel,
  output logic                    wb_stb,
  output logic                    wb_cyc,
  input  logic                    wb_ack
);

  localparam int CW = $clog2(timeout_cycles + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(timeout_cycles - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;

  // Ready is a pure state decode so it never loops back through req_valid.
  assign req_ready = (r_state == IDLE);

  // Bus-cycle sequencer; every bus and response output is a register here.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      wb_adr     <= '0;
      wb_datwr   <= '0;
      wb_we      <= 1'b0;
      wb_sel     <= '0;
      wb_stb     <= 1'b0;
      wb_cyc     <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req_valid) begin
            wb_adr   <= req_addr;
            wb_datwr <= req_data;
            wb_we    <= req_we;
            wb_sel   <= req_sel;
            wb_stb   <= 1'b1;
            wb_cyc   <= 1'b1;
            r_cnt    <= '0;
            r_state  <= BUS;
          end
        end
        BUS: begin
          if (wb_ack) begin
            wb_stb     <= 1'b0;
            wb_cyc     <= 1'b0;
            resp_data  <= wb_we ? '0 : wb_datrd;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            r_state    <= RESP;
          end else if (r_cnt == TO_LAST) begin
            wb_stb     <= 1'b0;
            wb_cyc     <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            r_state    <= RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
- Wishbone classic (B3, non-pipelined) master. Converts a valid/ready request/response channel pair into single Wishbone bus cycles.
- Sits between a copperv core-side port (instruction or data) and one master port of wb_xbar. It is the initiator end of the WishboneBus that the xbar's master ports accept.
- Issues one outstanding cycle at a time and reports a bus timeout as an error response.

Parameters:
- addr_width, 8, width of req_addr / wb_adr.
- data_width, 32, width of write/read data.
- strobe_width, data_width/8, byte-select width.
- timeout_cycles, 16, max cycles cyc/stb stay asserted without ack before abort; must be >= 1.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept request.
- req_addr  in  addr_width  target address.
- req_data  in  data_width  write data.
- req_we  in  1  1=write, 0=read.
- req_sel  in  strobe_width  byte enables.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_data  out  data_width  read data (0 for writes and errors).
- resp_err  out  1  1=cycle timed out.
- wb_adr  out  addr_width  Wishbone address.
- wb_datwr  out  data_width  Wishbone write data.
- wb_datrd  in  data_width  Wishbone read data.
- wb_we  out  1  Wishbone write enable.
- wb_sel  out  strobe_width  Wishbone byte select.
- wb_stb  out  1  Wishbone strobe.
- wb_cyc  out  1  Wishbone cycle.
- wb_ack  in  1  Wishbone acknowledge.

Behaviour:
- Reset (sync, active-high, sampled on clock edge): state=IDLE; timeout counter=0.
- Outputs after reset edge: wb_cyc=0, wb_stb=0, wb_we=0, wb_adr=0, wb_datwr=0, wb_sel=0, resp_valid=0, resp_data=0, resp_err=0, req_ready=1.
- Reset mid-cycle abandons the bus cycle: cyc/stb low on the next edge, no response is produced.
- All wb_* and resp_* outputs are registered. req_ready is a combinational decode of state only (IDLE=1, else 0); it never depends on req_valid.

FSM states: IDLE, BUS, RESP.
- IDLE -> BUS on req_valid & req_ready.
  - Latch addr/data/we/sel into wb_adr/wb_datwr/wb_we/wb_sel.
  - Set wb_cyc=wb_stb=1; clear timeout counter.
- BUS, no ack: wb_* held stable and counter increments each cycle.
- BUS -> RESP on wb_ack=1:
  - Drop cyc/stb at the next edge.
  - resp_data = wb_datrd if wb_we=0, else 0.
  - resp_err=0, resp_valid=1.
- BUS -> RESP on timeout (counter == timeout_cycles-1 and wb_ack=0):
  - Drop cyc/stb.
  - resp_data=0, resp_err=1, resp_valid=1.
  - The timeout counter is widened to hold timeout_cycles-1.
- Ack priority: wb_ack in the same cycle as the timeout condition counts as a normal completion (err=0).
- RESP -> IDLE on resp_ready=1. resp_valid clears at that edge; resp_data/resp_err hold their last value until the next response.
- RESP with resp_ready=0: response held stable indefinitely; no new request is accepted.

Latency and ordering:
- Request accepted at edge E0 -> cyc/stb high in cycle after E0.
- Ack sampled at edge Ek -> resp_valid high after Ek. cyc/stb is never asserted for a cycle after its ack is sampled.
- Back-to-back requests: minimum 1 idle cycle (IDLE) between cycles; cyc is low for at least one cycle between transactions.
- Stray wb_ack in IDLE or RESP is ignored and causes no state change.
- wb_we/wb_sel/wb_adr/wb_datwr change only on IDLE->BUS.

Test Plan:
- Read: req addr=0x10, we=0, sel=0xF; slave acks 2 cycles after stb with datrd=0xDEADBEEF -> cyc/stb high exactly 3 cycles, adr=0x10; resp_valid with resp_data=0xDEADBEEF, resp_err=0.
- Write: req addr=0x24, data=0x12345678, we=1, sel=0x3; slave acks first cycle -> cyc/stb high 1 cycle, datwr=0x12345678, sel=0x3; resp_data=0, resp_err=0.
- Timeout: timeout_cycles=16, slave never acks -> cyc/stb high exactly 16 cycles then low; resp_valid=1, resp_err=1, resp_data=0.
- Ack on timeout boundary: ack in 16th stb cycle with datrd=0xA5A5A5A5 -> resp_err=0, resp_data=0xA5A5A5A5.
- Backpressure: resp_ready=0 for 5 cycles, req_valid held with a second request -> req_ready=0 and resp stable for 5 cycles. Then resp_ready=1 -> IDLE, second request accepted the next cycle; cyc low at least 1 cycle between the two.
- Reset during BUS (cycle 2 of stb) plus stray ack in IDLE -> cyc/stb/resp_valid=0 the next edge, req_ready=1, no response ever emitted; stray ack causes no activity.
